// File: rtl/alu_rs.sv
// ALU reservation station: holds decoded ALU ops until operands arrive via CDB, dispatches one per cycle.
// Optional macro RS_CDB_BYPASS_EN lets an entry woken by a CDB this cycle dispatch in the same cycle.
module alu_rs #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned ROB_W   = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [5:0]       issue_type,
    input  logic [31:0]      issue_val1,
    input  logic [31:0]      issue_val2,
    input  logic             issue_q1_pend,
    input  logic             issue_q2_pend,
    input  logic [ROB_W-1:0] issue_q1,
    input  logic [ROB_W-1:0] issue_q2,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic [ROB_W-1:0] issue_rob_pos,
    output logic             rs_full,
    input  logic             cdb_alu_valid,
    input  logic [ROB_W-1:0] cdb_alu_tag,
    input  logic [31:0]      cdb_alu_val,
    input  logic             cdb_lsb_valid,
    input  logic [ROB_W-1:0] cdb_lsb_tag,
    input  logic [31:0]      cdb_lsb_val,
    output logic             alu_todo,
    output logic [5:0]       inst_type,
    output logic [31:0]      val1,
    output logic [31:0]      val2,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [ROB_W-1:0] rob_pos
);

    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic [5:0]       op;
        logic [31:0]      val1;
        logic [31:0]      val2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic             p1;
        logic             p2;
        logic [ROB_W-1:0] q1;
        logic [ROB_W-1:0] q2;
        logic [ROB_W-1:0] rob;
    } entry_t;

    entry_t             r_ent [RS_SIZE];
    logic [RS_SIZE-1:0] r_valid;

    entry_t             w_ent_nx [RS_SIZE];
    entry_t             w_iss;
    logic [RS_SIZE-1:0] w_ready;
    logic               w_sel_vld;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_free_vld;
    logic [IDX_W-1:0]   w_free_idx;

    // Returns {pend, value} after snooping both CDBs; ALU wins when both match.
    function automatic logic [32:0] wake(
        input logic             pend,
        input logic [ROB_W-1:0] q,
        input logic [31:0]      v,
        input logic             a_vld,
        input logic [ROB_W-1:0] a_tag,
        input logic [31:0]      a_val,
        input logic             l_vld,
        input logic [ROB_W-1:0] l_tag,
        input logic [31:0]      l_val
    );
        if (pend && a_vld && (q == a_tag)) return {1'b0, a_val};
        if (pend && l_vld && (q == l_tag)) return {1'b0, l_val};
        return {pend, v};
    endfunction

    assign rs_full = &r_valid;

    always_comb begin
        w_iss     = '0;
        w_iss.op  = issue_type;
        w_iss.imm = issue_imm;
        w_iss.pc  = issue_pc;
        w_iss.q1  = issue_q1;
        w_iss.q2  = issue_q2;
        w_iss.rob = issue_rob_pos;
        {w_iss.p1, w_iss.val1} = wake(issue_q1_pend, issue_q1, issue_val1,
                                      cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                      cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
        {w_iss.p2, w_iss.val2} = wake(issue_q2_pend, issue_q2, issue_val2,
                                      cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                      cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
    end

    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            w_ent_nx[i] = r_ent[i];
            {w_ent_nx[i].p1, w_ent_nx[i].val1} = wake(r_ent[i].p1, r_ent[i].q1, r_ent[i].val1,
                                                      cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                                      cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
            {w_ent_nx[i].p2, w_ent_nx[i].val2} = wake(r_ent[i].p2, r_ent[i].q2, r_ent[i].val2,
                                                      cdb_alu_valid, cdb_alu_tag, cdb_alu_val,
                                                      cdb_lsb_valid, cdb_lsb_tag, cdb_lsb_val);
`ifdef RS_CDB_BYPASS_EN
            w_ready[i] = r_valid[i] && !w_ent_nx[i].p1 && !w_ent_nx[i].p2;
`else
            w_ready[i] = r_valid[i] && !r_ent[i].p1 && !r_ent[i].p2;
`endif
        end
    end

    // Lowest-index picks: scanning downward leaves the smallest hit.
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_idx  = '0;
        w_free_vld = 1'b0;
        w_free_idx = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free_vld = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid   <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) r_ent[i] <= '0;
            alu_todo  <= 1'b0;
            inst_type <= '0;
            val1      <= '0;
            val2      <= '0;
            imm       <= '0;
            pc        <= '0;
            rob_pos   <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_valid  <= '0;
                alu_todo <= 1'b0;
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) r_ent[i] <= w_ent_nx[i];
                alu_todo <= w_sel_vld;
                if (w_sel_vld) begin
                    r_valid[w_sel_idx] <= 1'b0;
                    inst_type          <= w_ent_nx[w_sel_idx].op;
                    val1               <= w_ent_nx[w_sel_idx].val1;
                    val2               <= w_ent_nx[w_sel_idx].val2;
                    imm                <= w_ent_nx[w_sel_idx].imm;
                    pc                 <= w_ent_nx[w_sel_idx].pc;
                    rob_pos            <= w_ent_nx[w_sel_idx].rob;
                end
                // The free slot is never the dispatched one, so the two writes cannot collide.
                if (issue_valid && w_free_vld) begin
                    r_valid[w_free_idx] <= 1'b1;
                    r_ent[w_free_idx]   <= w_iss;
                end
            end
        end
    end

endmodule
